// File: rtl/password_pkg.sv
// Shared types and constants for the switch-sequence password lock and its status display.
// Glyphs are active-high, bit order {g,f,e,d,c,b,a}.
package password_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StDone    = 3'd2,
        StError   = 3'd3,
        StLockout = 3'd4
    } lock_state_e;

    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_O     = 7'h5C;
    localparam logic [6:0] SEG_N     = 7'h54;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_R     = 7'h50;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Digit k of a packed code; digit 0 occupies the least significant field.
    function automatic int unsigned code_digit(logic [31:0] code, int unsigned k,
                                               int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (code >> (k * idx_w)) & mask;
    endfunction

    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/password_status_display.sv
// Combinational 7-segment status decoder for the password lock; HEX3 is the leftmost digit.
module password_status_display
    import password_pkg::*;
#(
    parameter int unsigned PRG_W = 3
) (
    input  logic [2:0]       state,
    input  logic [PRG_W-1:0] progress,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3
);

    always_comb begin
        hex0 = SEG_BLANK;
        hex1 = SEG_BLANK;
        hex2 = SEG_BLANK;
        hex3 = SEG_BLANK;
        case (lock_state_e'(state))
            StEntry: begin
                // Dashes fill left to right, one per accepted digit, capped at four.
                if (32'(progress) >= 32'd1) hex3 = SEG_DASH;
                if (32'(progress) >= 32'd2) hex2 = SEG_DASH;
                if (32'(progress) >= 32'd3) hex1 = SEG_DASH;
                if (32'(progress) >= 32'd4) hex0 = SEG_DASH;
            end
            StDone: begin
                hex3 = SEG_D;
                hex2 = SEG_O;
                hex1 = SEG_N;
                hex0 = SEG_E;
            end
            StError: begin
                hex3 = SEG_E;
                hex2 = SEG_R;
                hex1 = SEG_R;
                hex0 = SEG_O;
            end
            StLockout: begin
                hex3 = SEG_DASH;
                hex2 = SEG_DASH;
                hex1 = SEG_DASH;
                hex0 = SEG_DASH;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/password_lock_param.sv
// Parametrised switch-sequence password lock with failure counting, timed lockout and hold windows.
// Define TIMEOUT_EN to abort an entry that sits idle for ENTRY_TIMEOUT cycles.
module password_lock_param
    import password_pkg::*;
#(
    parameter int unsigned NUM_SW        = 10,
    parameter int unsigned CODE_LEN      = 4,
    parameter logic [31:0] CODE          = 32'h8102,
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned HOLD_TICKS    = 8,
    parameter int unsigned LOCK_TICKS    = 32,
    parameter int unsigned ENTRY_TIMEOUT = 64,
    localparam int unsigned IDX_W = $clog2(NUM_SW),
    localparam int unsigned PRG_W = $clog2(CODE_LEN + 1),
    localparam int unsigned CNT_W = cnt_width(HOLD_TICKS, LOCK_TICKS, ENTRY_TIMEOUT)
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw_pulse,
    output logic [2:0]        state,
    output logic [PRG_W-1:0]  progress,
    output logic              unlocked,
    output logic              err,
    output logic              locked,
    output logic [3:0]        fail_cnt,
    output logic [CNT_W-1:0]  lock_remaining
);

    lock_state_e      state_q;
    logic [PRG_W-1:0] progress_q;
    logic [3:0]       fail_q;
    logic [CNT_W-1:0] tick_q;
    logic [CNT_W-1:0] lock_q;
    logic             unlocked_q;
    logic             err_q;
    logic             locked_q;

    logic [NUM_SW-1:0] want;
    logic              event_seen;
    logic              hit;
    logic              timeout;

    // progress_q is 0 in IDLE, so one expected-digit decode serves both IDLE and ENTRY.
    assign want       = NUM_SW'(1) << code_digit(CODE, 32'(progress_q), IDX_W);
    assign event_seen = |sw_pulse;
    assign hit        = (sw_pulse == want);

    always_comb begin
        timeout = 1'b0;
`ifdef TIMEOUT_EN
        timeout = (state_q == StEntry) && !event_seen &&
                  (tick_q == CNT_W'(ENTRY_TIMEOUT - 1));
`endif
    end

    always_ff @(posedge clk_div or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            progress_q <= '0;
            fail_q     <= '0;
            tick_q     <= '0;
            lock_q     <= '0;
            unlocked_q <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StEntry: begin
                    if ((event_seen && !hit) || timeout) begin
                        state_q    <= StError;
                        progress_q <= '0;
                        tick_q     <= '0;
                        err_q      <= 1'b1;
                        fail_q     <= (fail_q == 4'd15) ? fail_q : fail_q + 4'd1;
                    end else if (event_seen) begin
                        tick_q <= '0;
                        if (progress_q == PRG_W'(CODE_LEN - 1)) begin
                            state_q    <= StDone;
                            progress_q <= PRG_W'(CODE_LEN);
                            fail_q     <= '0;
                            unlocked_q <= 1'b1;
                        end else begin
                            state_q    <= StEntry;
                            progress_q <= progress_q + PRG_W'(1);
                        end
                    end
`ifdef TIMEOUT_EN
                    else if (state_q == StEntry) begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
`endif
                end
                StDone: begin
                    if (tick_q == CNT_W'(HOLD_TICKS - 1)) begin
                        state_q    <= StIdle;
                        progress_q <= '0;
                        tick_q     <= '0;
                        unlocked_q <= 1'b0;
                    end else begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                StError: begin
                    if (tick_q == CNT_W'(HOLD_TICKS - 1)) begin
                        tick_q <= '0;
                        err_q  <= 1'b0;
                        if (32'(fail_q) >= MAX_FAIL) begin
                            state_q  <= StLockout;
                            lock_q   <= CNT_W'(LOCK_TICKS);
                            locked_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        tick_q <= tick_q + CNT_W'(1);
                    end
                end
                StLockout: begin
                    if (lock_q == CNT_W'(1) || lock_q == '0) begin
                        state_q  <= StIdle;
                        lock_q   <= '0;
                        fail_q   <= '0;
                        locked_q <= 1'b0;
                    end else begin
                        lock_q <= lock_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    progress_q <= '0;
                    tick_q     <= '0;
                    lock_q     <= '0;
                    unlocked_q <= 1'b0;
                    err_q      <= 1'b0;
                    locked_q   <= 1'b0;
                end
            endcase
        end
    end

    assign state          = state_q;
    assign progress       = progress_q;
    assign unlocked       = unlocked_q;
    assign err            = err_q;
    assign locked         = locked_q;
    assign fail_cnt       = fail_q;
    assign lock_remaining = lock_q;

endmodule

// File: tb/tb_password_lock_param.sv
// Scoreboard bench for password_lock_param (default parameters) and its status display.
module tb_password_lock_param;

    localparam int unsigned PRG_W = 3;
    localparam int unsigned CNT_W = 7;

    localparam logic [6:0] G_D    = 7'h5E;
    localparam logic [6:0] G_O    = 7'h5C;
    localparam logic [6:0] G_N    = 7'h54;
    localparam logic [6:0] G_E    = 7'h79;
    localparam logic [6:0] G_R    = 7'h50;
    localparam logic [6:0] G_DASH = 7'h40;

    logic             clk_div = 1'b0;
    logic             rst = 1'b0;
    logic [9:0]       sw_pulse = '0;
    logic [2:0]       state;
    logic [PRG_W-1:0] progress;
    logic             unlocked;
    logic             err;
    logic             locked;
    logic [3:0]       fail_cnt;
    logic [CNT_W-1:0] lock_remaining;
    logic [6:0]       hex0, hex1, hex2, hex3;

    always #5 clk_div = ~clk_div;

    password_lock_param dut (
        .clk_div        (clk_div),
        .rst            (rst),
        .sw_pulse       (sw_pulse),
        .state          (state),
        .progress       (progress),
        .unlocked       (unlocked),
        .err            (err),
        .locked         (locked),
        .fail_cnt       (fail_cnt),
        .lock_remaining (lock_remaining)
    );

    password_status_display #(.PRG_W(PRG_W)) disp (
        .state    (state),
        .progress (progress),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3)
    );

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [2:0]  prg;
        logic [3:0]  fc;
        logic [6:0]  lr;
        bit          chk_hex;
        logic [27:0] hex;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [9:0] bitp(input int i);
        logic [9:0] one;
        one = 10'd1;
        return one << i;
    endfunction

    // Monitor: one expected snapshot per clock edge or reset assertion, when one is queued.
    initial begin
        exp_t        e;
        logic [19:0] act;
        logic [19:0] req;
        forever begin
            @(posedge clk_div or negedge rst);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {state, progress, unlocked, err, locked, fail_cnt, lock_remaining};
                req = {e.st, e.prg, e.st == 3'd2, e.st == 3'd3, e.st == 3'd4, e.fc, e.lr};
                n_cmp++;
                if (act !== req) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d prg=%0d unl=%0b err=%0b lck=%0b fc=%0d lr=%0d, required st=%0d prg=%0d unl=%0b err=%0b lck=%0b fc=%0d lr=%0d",
                             e.tag, state, progress, unlocked, err, locked, fail_cnt,
                             lock_remaining, e.st, e.prg, req[13], req[12], req[11], e.fc, e.lr);
                end
                if (e.chk_hex) begin
                    n_cmp++;
                    if ({hex3, hex2, hex1, hex0} !== e.hex) begin
                        n_bad++;
                        $display("FAIL %s_hex: got %h, required %h", e.tag,
                                 {hex3, hex2, hex1, hex0}, e.hex);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [9:0] p, input string tag, input int st, input int prg,
                       input int fc, input int lr, input bit chk_hex = 1'b0,
                       input logic [27:0] hex = '0);
        exp_t e;
        @(negedge clk_div);
        sw_pulse  = p;
        e.tag     = tag;
        e.st      = 3'(st);
        e.prg     = 3'(prg);
        e.fc      = 4'(fc);
        e.lr      = 7'(lr);
        e.chk_hex = chk_hex;
        e.hex     = hex;
        sb.push_back(e);
        @(posedge clk_div);
    endtask

    // n cycles of unchanged expectations; p is driven on the third one and must be ignored.
    task automatic hold(input int n, input logic [9:0] p, input string tag, input int st,
                        input int prg, input int fc, input int lr);
        for (int i = 0; i < n; i++) begin
            cyc((i == 2) ? p : 10'd0, tag, st, prg, fc, lr);
        end
    endtask

    task automatic rst_pulse(input string tag);
        exp_t e;
        @(negedge clk_div);
        sw_pulse  = '0;
        e.tag     = tag;
        e.st      = 3'd0;
        e.prg     = 3'd0;
        e.fc      = 4'd0;
        e.lr      = 7'd0;
        e.chk_hex = 1'b1;
        e.hex     = '0;
        sb.push_back(e);
        #2 rst = 1'b0;
        @(negedge clk_div);
        rst = 1'b1;
    endtask

    task automatic three_fails(input string tag);
        for (int a = 1; a <= 3; a++) begin
            cyc(bitp(7), tag, 3, 0, a, 0);
            hold(7, bitp(2), tag, 3, 0, a, 0);
            if (a < 3) cyc(10'd0, tag, 0, 0, a, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] p;
        // Reset state
        cyc(10'd0, "reset", 0, 0, 0, 0, 1'b1, 28'h0);
        @(negedge clk_div);
        rst = 1'b1;

        // Correct code 2,0,1,8 with gaps
        cyc(bitp(2), "t1_d0", 1, 1, 0, 0);
        cyc(10'd0,   "t1_gap", 1, 1, 0, 0);
        cyc(bitp(0), "t1_d1", 1, 2, 0, 0);
        cyc(10'd0,   "t1_gap", 1, 2, 0, 0);
        cyc(bitp(1), "t1_d2", 1, 3, 0, 0);
        cyc(10'd0,   "t1_gap", 1, 3, 0, 0);
        cyc(bitp(8), "t1_done", 2, 4, 0, 0, 1'b1, {G_D, G_O, G_N, G_E});
        hold(7, bitp(2), "t1_done_hold", 2, 4, 0, 0);
        cyc(bitp(2), "t1_expiry_pulse", 0, 0, 0, 0);

        // Wrong second digit
        cyc(bitp(2), "t2_d0", 1, 1, 0, 0);
        cyc(bitp(5), "t2_err", 3, 0, 1, 0, 1'b1, {G_E, G_R, G_R, G_O});
        hold(7, bitp(2), "t2_err_hold", 3, 0, 1, 0);
        cyc(bitp(2), "t2_expiry_pulse", 0, 0, 1, 0);

        // Reset mid-entry
        cyc(bitp(2), "t5_d0", 1, 1, 1, 0);
        cyc(bitp(0), "t5_d1", 1, 2, 1, 0, 1'b1, {G_DASH, G_DASH, 7'h00, 7'h00});
        rst_pulse("t5_rst_entry");

        // Lockout after three failures; correct code during lockout is ignored
        three_fails("t3_fail");
        cyc(10'd0, "t3_lock", 4, 0, 3, 32, 1'b1, {G_DASH, G_DASH, G_DASH, G_DASH});
        for (int r = 31; r >= 1; r--) begin
            case (r)
                30:      p = bitp(2);
                28:      p = bitp(0);
                26:      p = bitp(1);
                24:      p = bitp(8);
                default: p = 10'd0;
            endcase
            cyc(p, "t3_lock_count", 4, 0, 3, r);
        end
        cyc(bitp(2), "t3_lock_exit", 0, 0, 0, 0);
        cyc(10'd0,   "t3_idle", 0, 0, 0, 0);

        // Reset mid-lockout
        three_fails("t5_fail");
        cyc(10'd0, "t5_lock", 4, 0, 3, 32);
        cyc(10'd0, "t5_lock", 4, 0, 3, 31);
        cyc(10'd0, "t5_lock", 4, 0, 3, 30);
        rst_pulse("t5_rst_lock");
        cyc(10'd0, "t5_after", 0, 0, 0, 0);

        // Multi-bit entry, a wrong digit, then the correct code clears fail_cnt
        cyc(bitp(2) | bitp(0), "t4_multi", 3, 0, 1, 0);
        hold(7, 10'd0, "t4_err_hold", 3, 0, 1, 0);
        cyc(10'd0,   "t4_idle1", 0, 0, 1, 0);
        cyc(bitp(2), "t4_d0", 1, 1, 1, 0);
        cyc(bitp(9), "t4_err2", 3, 0, 2, 0);
        hold(7, bitp(3), "t4_err2_hold", 3, 0, 2, 0);
        cyc(10'd0,   "t4_idle2", 0, 0, 2, 0);
        cyc(bitp(2), "t4_c0", 1, 1, 2, 0);
        cyc(bitp(0), "t4_c1", 1, 2, 2, 0);
        cyc(bitp(1), "t4_c2", 1, 3, 2, 0);
        cyc(bitp(8), "t4_done", 2, 4, 0, 0);
        hold(7, 10'd0, "t4_done_hold", 2, 4, 0, 0);
        cyc(10'd0,   "t4_idle3", 0, 0, 0, 0);

        // Entry timeout
        cyc(bitp(2), "t6_d0", 1, 1, 0, 0);
`ifdef TIMEOUT_EN
        hold(63, 10'd0, "t6_wait", 1, 1, 0, 0);
        cyc(10'd0, "t6_timeout", 3, 0, 1, 0);
`else
        hold(1000, 10'd0, "t6_wait", 1, 1, 0, 0);
`endif

        @(negedge clk_div);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
